// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction-memory, redirect and decode-side signals of the fetch unit.
interface instruction_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner, credit-limited fetch issue and in-order prefetch FIFO to decode.
// Defining IFETCH_PERF_COUNTERS_EN adds perf_fetched/perf_dropped counters.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
`ifdef IFETCH_PERF_COUNTERS_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped,
`endif
    instruction_fetch_unit_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [31:0]   fetch_pc, resp_pc, hold_data, hold_pc;
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, outstanding, drop;
    logic [CW:0]   in_use;
    logic          started, empty, fire, resp, keep, pop, unused_pc_bits;
    assign unused_pc_bits = ^bus.redirect_pc[1:0];
    assign empty  = count == '0;
    assign in_use = {1'b0, count} + {1'b0, outstanding};
    // Buffered plus in-flight fetches never exceed the FIFO, so a kept response always has room.
    assign bus.imem_req_valid = started && in_use < (CW+1)'(FIFO_DEPTH) && !bus.redirect_valid;
    assign bus.imem_addr      = fetch_pc;
    assign fire = bus.imem_req_valid && bus.imem_req_ready;
    assign resp = bus.imem_resp_valid;
    assign keep = resp && drop == '0 && !bus.redirect_valid;
    assign bus.inst_valid = !empty && !bus.redirect_valid;
    assign pop            = bus.inst_valid && bus.inst_ready;
    assign bus.inst_data  = empty ? hold_data : fifo_data[rd_ptr];
    assign bus.inst_pc    = empty ? hold_pc : fifo_pc[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            hold_data   <= '0;
            hold_pc     <= '0;
        end else begin
            started     <= 1'b1;
            outstanding <= outstanding + CW'(fire) - CW'(resp);
            if (pop) begin
                hold_data <= fifo_data[rd_ptr];
                hold_pc   <= fifo_pc[rd_ptr];
            end
            if (bus.redirect_valid) begin
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                resp_pc  <= {bus.redirect_pc[31:2], 2'b00};
                drop     <= outstanding - CW'(resp);
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (fire) fetch_pc <= fetch_pc + 32'd4;
                if (keep) resp_pc <= resp_pc + 32'd4;
                if (resp && drop != '0) drop <= drop - CW'(1);
                if (keep) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(keep) - CW'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (keep) begin
            fifo_pc[wr_ptr]   <= resp_pc;
            fifo_data[wr_ptr] <= bus.imem_resp_data;
        end
    end
`ifdef IFETCH_PERF_COUNTERS_EN
    // Dropped = discarded responses plus entries flushed by a redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(keep);
            perf_dropped <= perf_dropped + 32'(resp && !keep) + (bus.redirect_valid ? 32'(count) : 32'd0);
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of issue, backpressure, redirects, PC wrap and reset.
module tb_instruction_fetch_unit;
    localparam int FIFO_DEPTH = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    instruction_fetch_unit_if bus ();
    instruction_fetch_unit_if bus2 ();
`ifdef IFETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched, perf_dropped, perf_fetched2, perf_dropped2;
`endif
    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef IFETCH_PERF_COUNTERS_EN
        .perf_fetched(perf_fetched),
        .perf_dropped(perf_dropped),
`endif
        .bus(bus.master)
    );
    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(FIFO_DEPTH)) dut2 (
        .clk(clk),
        .rst_n(rst_n),
`ifdef IFETCH_PERF_COUNTERS_EN
        .perf_fetched(perf_fetched2),
        .perf_dropped(perf_dropped2),
`endif
        .bus(bus2.master)
    );
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat = 1;
    int req_cnt = 0;
    int resp_cnt = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] log_pc[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];
    logic [31:0] log2[$];
    logic        fire2;
    logic [31:0] addr2;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction
    function automatic logic [31:0] lpc(input int i);
        return (i < log_pc.size()) ? log_pc[i] : 32'hxxxx_xxxx;
    endfunction
    function automatic logic [31:0] ldata(input int i);
        return (i < log_data.size()) ? log_data[i] : 32'hxxxx_xxxx;
    endfunction
    function automatic int lcyc(input int i);
        return (i < log_cyc.size()) ? log_cyc[i] : -1000;
    endfunction
    function automatic logic [31:0] lpc2(input int i);
        return (i < log2.size()) ? log2[i] : 32'hxxxx_xxxx;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    always @(negedge clk) cyc++;
    // In-order memory for dut with a programmable fixed latency.
    always @(posedge clk) begin
        if (!rst_n) begin
            q_addr.delete();
            q_due.delete();
        end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            q_addr.push_back(bus.imem_addr);
            q_due.push_back(cyc + lat);
            req_cnt++;
        end
        #1;
        if (rst_n && q_due.size() > 0 && q_due[0] <= cyc + 1) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(q_addr.pop_front());
            void'(q_due.pop_front());
            resp_cnt++;
        end else begin
            bus.imem_resp_valid = 1'b0;
        end
    end
    always @(posedge clk) begin
        if (rst_n && bus.inst_valid && bus.inst_ready) begin
            log_pc.push_back(bus.inst_pc);
            log_data.push_back(bus.inst_data);
            log_cyc.push_back(cyc);
        end
    end
    always @(posedge clk) begin
        fire2 = bus2.imem_req_valid && bus2.imem_req_ready;
        addr2 = bus2.imem_addr;
        if (rst_n && bus2.inst_valid && log2.size() < 3) log2.push_back(bus2.inst_pc);
        #1;
        bus2.imem_resp_valid = fire2 && rst_n;
        bus2.imem_resp_data  = mem_word(addr2);
    end
    always @(negedge clk) begin
        if (rst_n) begin
            n_chk++;
            assert (!(dut.keep && !dut.pop && int'(dut.count) == FIFO_DEPTH)) else begin
                n_fail++;
                $error("FAIL fifo_overflow: push into full FIFO, count %0d required below %0d", dut.count, FIFO_DEPTH);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed %0d checks", n_chk);
        $fatal(1, "timeout");
    end
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        req_cnt = 0;
        resp_cnt = 0;
        log_pc.delete();
        log_data.delete();
        log_cyc.delete();
        rst_n = 1'b1;
    endtask
    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (log_pc.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("log_count", 32'(log_pc.size()), 32'(n));
    endtask
    initial begin
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.inst_ready      = 1'b1;
        bus2.imem_req_ready  = 1'b1;
        bus2.imem_resp_valid = 1'b0;
        bus2.imem_resp_data  = '0;
        bus2.redirect_valid  = 1'b0;
        bus2.redirect_pc     = '0;
        bus2.inst_ready      = 1'b1;
        tick();
        tick();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst_data", bus.inst_data, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_addr2", bus2.imem_addr, 32'hFFFF_FFF8);
`ifdef IFETCH_PERF_COUNTERS_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_dropped", perf_dropped, 32'd0);
`endif
        rst_n = 1'b1;
        #1 chk("req_valid_before_edge", 32'(bus.imem_req_valid), 32'd0);
        tick();
        chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("first_req_addr", bus.imem_addr, 32'h0);
        wait_log(8, 40);
        for (int i = 0; i < 8; i++) begin
            chk("stream_pc", lpc(i), 32'(4 * i));
            chk("stream_data", ldata(i), mem_word(32'(4 * i)));
        end
        chk("stream_throughput", 32'(lcyc(7) - lcyc(0)), 32'd7);
        chk("wrap_pc0", lpc2(0), 32'hFFFF_FFF8);
        chk("wrap_pc1", lpc2(1), 32'hFFFF_FFFC);
        chk("wrap_pc2", lpc2(2), 32'h0000_0000);
        // Backpressure: decode stalled from reset release.
        bus.inst_ready = 1'b0;
        do_reset();
        repeat (20) tick();
        chk("bp_req_cnt", 32'(req_cnt), 32'd4);
        chk("bp_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("bp_inst_valid", 32'(bus.inst_valid), 32'd1);
        chk("bp_inst_pc", bus.inst_pc, 32'h0);
        chk("bp_no_pops", 32'(log_pc.size()), 32'd0);
`ifdef IFETCH_PERF_COUNTERS_EN
        chk("bp_perf_fetched", perf_fetched, 32'd4);
        chk("bp_perf_dropped", perf_dropped, 32'd0);
`endif
        bus.inst_ready = 1'b1;
        wait_log(6, 30);
        for (int i = 0; i < 6; i++) begin
            chk("bp_pc", lpc(i), 32'(4 * i));
            chk("bp_data", ldata(i), mem_word(32'(4 * i)));
        end
        // Reset with two entries buffered and two requests in flight.
        lat = 3;
        bus.inst_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 20 && resp_cnt < 3; k++) tick();
        chk("mid_resp_cnt", 32'(resp_cnt), 32'd3);
        chk("mid_req_cnt", 32'(req_cnt), 32'd4);
        chk("mid_inst_valid", 32'(bus.inst_valid), 32'd1);
        chk("mid_inst_pc", bus.inst_pc, 32'h0);
`ifdef IFETCH_PERF_COUNTERS_EN
        chk("mid_perf_fetched", perf_fetched, 32'd2);
`endif
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("mid_rst_addr", bus.imem_addr, 32'h0);
        chk("mid_rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("mid_rst_inst_data", bus.inst_data, 32'h0);
        chk("mid_rst_inst_pc", bus.inst_pc, 32'h0);
`ifdef IFETCH_PERF_COUNTERS_EN
        chk("mid_rst_perf_fetched", perf_fetched, 32'd0);
        chk("mid_rst_perf_dropped", perf_dropped, 32'd0);
`endif
        lat = 1;
        bus.inst_ready = 1'b1;
        do_reset();
        wait_log(3, 20);
        for (int i = 0; i < 3; i++) chk("post_rst_pc", lpc(i), 32'(4 * i));
        // Redirect with three requests in flight at latency 3.
        lat = 3;
        do_reset();
        for (int k = 0; k < 20 && req_cnt < 3; k++) tick();
        chk("redir_req_cnt", 32'(req_cnt), 32'd3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h48;
        #1;
        chk("redir_req_blocked", 32'(bus.imem_req_valid), 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("redir_next_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("redir_next_addr", bus.imem_addr, 32'h48);
        wait_log(2, 30);
        chk("redir_pc0", lpc(0), 32'h48);
        chk("redir_pc1", lpc(1), 32'h4C);
        chk("redir_data0", ldata(0), mem_word(32'h48));
`ifdef IFETCH_PERF_COUNTERS_EN
        chk("redir_perf_dropped", perf_dropped, 32'd3);
`endif
        // Redirect landing on a response cycle, unaligned target.
        for (int k = 0; k < 10 && !bus.imem_resp_valid; k++) tick();
        chk("coinc_resp_present", 32'(bus.imem_resp_valid), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h103;
        log_pc.delete();
        log_data.delete();
        log_cyc.delete();
        #1;
        chk("coinc_inst_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("coinc_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("coinc_addr", bus.imem_addr, 32'h100);
        wait_log(3, 30);
        for (int i = 0; i < 3; i++) begin
            chk("coinc_pc", lpc(i), 32'h100 + 32'(4 * i));
            chk("coinc_data", ldata(i), mem_word(32'h100 + 32'(4 * i)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

- Initiator side of the instruction-memory interface.
- Owns the program counter and issues word-aligned fetch requests to instruction memory.
- Buffers returned instructions with their PCs in an in-order prefetch FIFO and presents them to decode over a valid/ready handshake.
- A branch/jump redirect flushes buffered and in-flight fetches and restarts at the target.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- FIFO_DEPTH, 4: prefetch entries; power of two, 2..16; also the cap on buffered plus outstanding fetches.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  32  fetch address; bits [1:0] always 0.
- imem_resp_valid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  single-cycle redirect pulse.
- redirect_pc  in  32  redirect target; bits [1:0] ignored.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts head.
- inst_data  out  32  head instruction.
- inst_pc  out  32  head PC.

## Operation
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of next kept response.
  - FIFO of {pc, instr}.
  - outstanding: accepted requests not yet answered, 0..FIFO_DEPTH.
  - drop: responses still to discard, 0..FIFO_DEPTH.
- Reset values:
  - fetch_pc = resp_pc = RESET_PC; outstanding = drop = 0; FIFO empty.
  - Outputs: imem_req_valid = 0, imem_addr = RESET_PC, inst_valid = 0, inst_data = 0, inst_pc = 0.
- Issue:
  - imem_req_valid = (count + outstanding < FIFO_DEPTH) && !redirect_valid; imem_addr = fetch_pc.
  - On handshake: fetch_pc += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0); outstanding++.
- Response:
  - Each imem_resp_valid decrements outstanding.
  - If drop > 0: discard the response and decrement drop.
  - Otherwise: push {resp_pc, data} and resp_pc += 4 with the same wrap.
  - A FIFO overflow is impossible by the credit rule; a push into a full FIFO is a bench assertion failure.
- Output:
  - Show-ahead FIFO head drives inst_*.
  - inst_valid = !empty && !redirect_valid; pop on inst_valid && inst_ready.
  - inst_data/inst_pc hold the last value when empty.
- Simultaneous events:
  - Push and pop in the same cycle keeps count unchanged, including when full.
  - Issue and response in the same cycle leaves outstanding unchanged.
- Redirect (redirect_valid=1), applied at the edge ending that cycle:
  - FIFO cleared.
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - drop = outstanding minus any response arriving this cycle; that response is also discarded.
  - outstanding keeps normal accounting.
  - No request is issued and no pop occurs in the redirect cycle.
- Back-to-back redirects: the later one wins; drop accumulates correctly because it is always set from the live outstanding count.
- Reset mid-operation: all state returns to reset values immediately, regardless of in-flight responses. The memory must also be reset.

## Timing
- First request: imem_req_valid rises in the first cycle after rst_n deasserts (visible after the first clk edge).
- Fetch latency: request accepted at cycle N, response at N+L, inst_valid at N+L+1.
- Throughput: one instruction per cycle with zero-wait memory and inst_ready held high.
- Redirect: the first request to the target is issued in the cycle after redirect_valid.
- Backpressure: with inst_ready low, requests stop once count + outstanding = FIFO_DEPTH.

## Configuration
- IFETCH_PERF_COUNTERS_EN defined:
  - Adds outputs perf_fetched (32) and perf_dropped (32).
  - perf_fetched counts pushed instructions; perf_dropped counts discarded responses plus FIFO entries flushed by redirect.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and logic absent; behaviour otherwise identical.

## Test plan
- Reset release, zero-wait memory, inst_ready=1 -> inst_pc 0x0,0x4,0x8,… on consecutive cycles starting 2 cycles after reset; data matches memory words.
- inst_ready=0 for 20 cycles, FIFO_DEPTH=4 -> exactly 4 requests issued, imem_req_valid low thereafter; on release, PCs continue 0x10, 0x14 with no gap or duplicate.
- Memory latency 3, 3 requests outstanding, redirect_pc=0x48 -> 3 stale responses discarded; next inst_pc=0x48 then 0x4C.
- Redirect in the same cycle as a response, redirect_pc=0x103 -> response discarded; fetch restarts at 0x100; no stale PC reaches decode.
- RESET_PC=0xFFFF_FFF8 -> inst_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst_n asserted with 2 requests outstanding and FIFO half full -> outputs at reset values the same cycle; after release, fetch resumes at RESET_PC. With IFETCH_PERF_COUNTERS_EN, counters read 0.
